// File: rtl/mem_op_pkg.sv
// Shared types and codes for the memory operation controller.
package mem_op_pkg;

   typedef enum logic [2:0] {
      OP_WRITE = 3'd0,
      OP_READ  = 3'd1,
      OP_FILL  = 3'd2,
      OP_DUMP  = 3'd3
   } op_e;

   typedef enum logic [1:0] {
      SEL_ADDR   = 2'd0,
      SEL_BEGIN  = 2'd1,
      SEL_MIDDLE = 2'd2,
      SEL_END    = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DUMP = 2'd2
   } state_e;

   localparam logic [3:0] STAT_WRITE   = 4'h1;
   localparam logic [3:0] STAT_READ    = 4'h2;
   localparam logic [3:0] STAT_FILL    = 4'h3;
   localparam logic [3:0] STAT_DUMP    = 4'h4;
   localparam logic [3:0] STAT_ILLEGAL = 4'hF;

endpackage

// File: rtl/mem_op_target.sv
// Decodes the request selector into a concrete word address.
module mem_op_target
   import mem_op_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic [1:0]        i_sel,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ADDR_W-1:0] o_target
);

   localparam logic [ADDR_W-1:0] MIDDLE = ADDR_W'(2 ** (ADDR_W - 1));

   always_comb begin
      o_target = i_addr;
      case (i_sel)
         SEL_ADDR:   o_target = i_addr;
         SEL_BEGIN:  o_target = '0;
         SEL_MIDDLE: o_target = MIDDLE;
         SEL_END:    o_target = '1;
         default:    o_target = i_addr;
      endcase
   end

endmodule

// File: rtl/mem_op_ctrl.sv
// Small register-array memory with single-word WRITE/READ and whole-array FILL/DUMP.
module mem_op_ctrl
   import mem_op_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [1:0]        req_sel,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_last,
   output logic              done,
   output logic [3:0]        status,
   output logic              busy
);

   localparam int              DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_e            r_state;
   logic [ADDR_W:0]   r_cnt;
   logic [DATA_W-1:0] r_fill_data;

   logic [ADDR_W-1:0] w_target;
   logic              w_accept;
   logic [ADDR_W:0]   w_cnt_nxt;
   logic              w_cnt_end;
   logic [ADDR_W-1:0] w_cnt_addr;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;

   mem_op_target #(.ADDR_W(ADDR_W)) u_target (
      .i_sel    (req_sel),
      .i_addr   (req_addr),
      .o_target (w_target)
   );

   assign req_ready  = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_FILL) || (r_state == ST_DUMP);
   assign w_accept   = req_valid && req_ready;
   assign w_cnt_nxt  = r_cnt + 1'b1;
   // Counter runs one bit wider than the address so the end test never aliases word 0.
   assign w_cnt_end  = (w_cnt_nxt == DEPTH_CNT);
   assign w_cnt_addr = r_cnt[ADDR_W-1:0];

   always_comb begin
      w_we    = 1'b0;
      w_waddr = w_target;
      w_wdata = req_wdata;
      if (r_state == ST_FILL) begin
         w_we    = 1'b1;
         w_waddr = w_cnt_addr;
         w_wdata = r_fill_data;
      end else if (w_accept && (req_op == OP_WRITE)) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_fill_data <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_addr    <= '0;
         rsp_last    <= 1'b0;
         done        <= 1'b0;
         status      <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (req_op)
                     OP_WRITE: begin
                        done   <= 1'b1;
                        status <= STAT_WRITE;
                     end
                     OP_READ: begin
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_data  <= r_mem[w_target];
                        rsp_addr  <= w_target;
                        done      <= 1'b1;
                        status    <= STAT_READ;
                     end
                     OP_FILL: begin
                        r_fill_data <= req_wdata;
                        r_cnt       <= '0;
                        r_state     <= ST_FILL;
                     end
                     OP_DUMP: begin
                        r_cnt   <= '0;
                        r_state <= ST_DUMP;
                     end
                     default: begin
                        done   <= 1'b1;
                        status <= STAT_ILLEGAL;
                     end
                  endcase
               end
            end
            ST_FILL: begin
               r_cnt <= w_cnt_nxt;
               if (w_cnt_end) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
                  done    <= 1'b1;
                  status  <= STAT_FILL;
               end
            end
            ST_DUMP: begin
               rsp_valid <= 1'b1;
               rsp_data  <= r_mem[w_cnt_addr];
               rsp_addr  <= w_cnt_addr;
               r_cnt     <= w_cnt_nxt;
               if (w_cnt_end) begin
                  r_cnt    <= '0;
                  r_state  <= ST_IDLE;
                  rsp_last <= 1'b1;
                  done     <= 1'b1;
                  status   <= STAT_DUMP;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_op_ctrl.sv
// Directed vector table plus FILL/DUMP/abort sequences for mem_op_ctrl (DATA_W=32, ADDR_W=3).
module tb_mem_op_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [1:0]  req_sel = '0;
   logic [2:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [2:0]  rsp_addr;
   logic        rsp_last;
   logic        done;
   logic [3:0]  status;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   mem_op_ctrl #(.DATA_W(32), .ADDR_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_sel   (req_sel),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .rsp_last  (rsp_last),
      .done      (done),
      .status    (status),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sel;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  st;
      logic        rv;
      logic [31:0] rd;
      logic [2:0]  ra;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [1:0] sel,
                        input logic [2:0] addr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_op    = op;
      req_sel   = sel;
      req_addr  = addr;
      req_wdata = wd;
   endtask

   // Call at a negedge, one cycle after the DUMP was accepted.
   task automatic dump_check(input string nm, input logic [31:0] exp);
      int t = 0;
      while (rsp_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_start"}, 32'(rsp_valid), 32'd1);
      if (rsp_valid === 1'b1) begin
         for (int w = 0; w < 8; w++) begin
            chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, "_addr"},  32'(rsp_addr), 32'(w));
            chk({nm, "_data"},  rsp_data, exp);
            chk({nm, "_last"},  32'(rsp_last), 32'(w == 7));
            chk({nm, "_done"},  32'(done), 32'(w == 7));
            if (w == 7) chk({nm, "_status"}, 32'(status), 32'h4);
            @(negedge clk);
         end
         chk({nm, "_after"}, 32'(rsp_valid), 32'd0);
         chk({nm, "_ready"}, 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      int t;
      tv[0]  = '{3'd1, 2'd3, 3'd0, 32'h0,         4'h2, 1'b1, 32'h0,         3'd7};
      tv[1]  = '{3'd0, 2'd2, 3'd0, 32'hA5A5_0001, 4'h1, 1'b0, 32'h0,         3'd0};
      tv[2]  = '{3'd1, 2'd0, 3'd4, 32'h0,         4'h2, 1'b1, 32'hA5A5_0001, 3'd4};
      tv[3]  = '{3'd0, 2'd1, 3'd6, 32'h1111_2222, 4'h1, 1'b0, 32'h0,         3'd0};
      tv[4]  = '{3'd1, 2'd0, 3'd0, 32'h0,         4'h2, 1'b1, 32'h1111_2222, 3'd0};
      tv[5]  = '{3'd0, 2'd3, 3'd1, 32'h3333_4444, 4'h1, 1'b0, 32'h0,         3'd0};
      tv[6]  = '{3'd0, 2'd0, 3'd3, 32'h0000_00C3, 4'h1, 1'b0, 32'h0,         3'd0};
      tv[7]  = '{3'd1, 2'd3, 3'd2, 32'h0,         4'h2, 1'b1, 32'h3333_4444, 3'd7};
      tv[8]  = '{3'd1, 2'd0, 3'd3, 32'h0,         4'h2, 1'b1, 32'h0000_00C3, 3'd3};
      tv[9]  = '{3'd6, 2'd0, 3'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         3'd0};
      tv[10] = '{3'd1, 2'd0, 3'd3, 32'h0,         4'h2, 1'b1, 32'h0000_00C3, 3'd3};
      tv[11] = '{3'd1, 2'd2, 3'd1, 32'h1234_5678, 4'h2, 1'b1, 32'hA5A5_0001, 3'd4};
      tv[12] = '{3'd7, 2'd3, 3'd0, 32'h0,         4'hF, 1'b0, 32'h0,         3'd0};
      tv[13] = '{3'd1, 2'd1, 3'd5, 32'h0,         4'h2, 1'b1, 32'h1111_2222, 3'd0};
      tv[14] = '{3'd1, 2'd0, 3'd5, 32'h0,         4'h2, 1'b1, 32'h0,         3'd5};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  rsp_data, 32'd0);
      chk("rst_rsp_addr",  32'(rsp_addr), 32'd0);
      chk("rst_rsp_last",  32'(rsp_last), 32'd0);
      chk("rst_done",      32'(done), 32'd0);
      chk("rst_status",    32'(status), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);

      // Back-to-back single-cycle ops; vector 0 lands on the first edge after release
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 0) begin
            rst = 1'b0;
            chk("ready_after_rst", 32'(req_ready), 32'd1);
         end
         drive(tv[i].op, tv[i].sel, tv[i].addr, tv[i].wdata);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done", i),      32'(done), 32'd1);
         chk($sformatf("v%0d_status", i),    32'(status), 32'(tv[i].st));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tv[i].rv));
         chk($sformatf("v%0d_busy", i),      32'(busy), 32'd0);
         if (tv[i].rv) begin
            chk($sformatf("v%0d_rsp_data", i), rsp_data, tv[i].rd);
            chk($sformatf("v%0d_rsp_addr", i), 32'(rsp_addr), 32'(tv[i].ra));
            chk($sformatf("v%0d_rsp_last", i), 32'(rsp_last), 32'd1);
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("done_pulse_drop", 32'(done), 32'd0);
      chk("status_held",     32'(status), 32'h2);

      // FILL: busy for 8 cycles, then done/status 3
      @(negedge clk);
      drive(3'd2, 2'd0, 3'd0, 32'hDEAD_BEEF);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fill_busy%0d", k),  32'(busy), 32'd1);
         chk($sformatf("fill_ready%0d", k), 32'(req_ready), 32'd0);
         chk($sformatf("fill_done%0d", k),  32'(done), 32'd0);
         @(negedge clk);
      end
      chk("fill_done",   32'(done), 32'd1);
      chk("fill_status", 32'(status), 32'h3);
      chk("fill_idle",   32'(busy), 32'd0);

      @(negedge clk);
      drive(3'd3, 2'd2, 3'd5, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      dump_check("dump1", 32'hDEAD_BEEF);

      // DUMP held during FILL: must wait for IDLE, then run on the new fill data
      @(negedge clk);
      drive(3'd2, 2'd3, 3'd1, 32'h0F0F_0F0F);
      @(negedge clk);
      drive(3'd3, 2'd0, 3'd2, 32'hBAD0_BAD0);
      t = 0;
      while (done !== 1'b1 && t < 20) begin
         chk("held_no_rsp", 32'(rsp_valid), 32'd0);
         @(negedge clk);
         t++;
      end
      chk("held_fill_done",   32'(done), 32'd1);
      chk("held_fill_status", 32'(status), 32'h3);
      @(negedge clk);
      req_valid = 1'b0;
      chk("held_dump_accepted", 32'(busy), 32'd1);
      dump_check("dump2", 32'h0F0F_0F0F);

      // Reserved op leaves memory untouched
      @(negedge clk);
      drive(3'd6, 2'd0, 3'd2, 32'h1111_1111);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rsv_done",      32'(done), 32'd1);
      chk("rsv_status",    32'(status), 32'hF);
      chk("rsv_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      drive(3'd3, 2'd0, 3'd0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      dump_check("dump3", 32'h0F0F_0F0F);

      // Reset mid-DUMP at word 3
      @(negedge clk);
      drive(3'd3, 2'd0, 3'd0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (rsp_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("abort_dump_started", 32'(rsp_valid), 32'd1);
      repeat (3) @(negedge clk);
      chk("abort_word3_addr", 32'(rsp_addr), 32'd3);
      rst = 1'b1;
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_done",      32'(done), 32'd0);
      chk("abort_busy",      32'(busy), 32'd0);
      chk("abort_status",    32'(status), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("abort_no_done%0d", k), 32'(done), 32'd0);
         chk($sformatf("abort_no_rsp%0d", k),  32'(rsp_valid), 32'd0);
      end
      drive(3'd3, 2'd0, 3'd0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      dump_check("dump4", 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_op_ctrl.md
MEM_OP_CTRL -- requirements
Module: mem_op_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of each memory word.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-007 req_op  input  3  0 WRITE, 1 READ, 2 FILL, 3 DUMP, 4-7 reserved.
REQ-008 req_sel  input  2  target for WRITE/READ: 0 req_addr, 1 begin (0), 2 middle (DEPTH/2), 3 end (DEPTH-1).
REQ-009 req_addr  input  ADDR_W  explicit address, used only when req_sel=0.
REQ-010 req_wdata  input  DATA_W  write/fill data.
REQ-011 rsp_valid  output  1  rsp_data/rsp_addr valid this cycle; no backpressure.
REQ-012 rsp_data  output  DATA_W  read data.
REQ-013 rsp_addr  output  ADDR_W  address of rsp_data.
REQ-014 rsp_last  output  1  final word of a DUMP (and high for a single READ).
REQ-015 done  output  1  one-cycle pulse when an operation completes.
REQ-016 status  output  4  code of last completed operation, held until next completion.
REQ-017 busy  output  1  high in FILL or DUMP state.

Function
REQ-018 FSM states IDLE, FILL, DUMP; WRITE/READ/illegal complete from IDLE without leaving it.
REQ-019 WRITE accepted at edge N: mem[target] = req_wdata at edge N; done=1, status=1 in cycle N+1.
REQ-020 READ accepted at edge N: rsp_valid=1, rsp_last=1, rsp_data=mem[target], rsp_addr=target, done=1, status=2 in cycle N+1.
REQ-021 FILL accepted: latch req_wdata, go FILL; write one word per cycle at addresses 0..DEPTH-1 (DEPTH cycles); done=1, status=3 in the cycle after the last write; return to IDLE.
REQ-022 DUMP accepted: go DUMP; rsp_valid high for DEPTH consecutive cycles, addresses 0..DEPTH-1 ascending; rsp_last and done=1, status=4 on the final word; return to IDLE.
REQ-023 Reserved op (4-7): memory unchanged, no rsp_valid; done=1, status=4'hF next cycle.
REQ-024 req_sel and req_addr ignored for FILL/DUMP; req_wdata ignored for READ/DUMP.
REQ-025 req_valid while busy is not accepted and has no effect; requester holds it.
REQ-026 Back-to-back WRITE then READ of the same address returns the new data (write at edge N, read at N+1).
REQ-027 FILL/DUMP word counter is ADDR_W+1 bits wide; terminates at DEPTH, no wrap into address 0.
REQ-028 Middle target = DEPTH/2 for all ADDR_W >= 1.

Reset
REQ-029 rst asserted: state=IDLE, all memory words 0, counter 0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, done=0, status=0, busy=0; req_ready=1 after release.
REQ-030 rst during FILL or DUMP aborts immediately; no done pulse for the aborted operation.
REQ-031 First request accepted on the first rising edge with rst low.

Structure
REQ-032 Shared package mem_op_pkg holds op enum (WRITE, READ, FILL, DUMP), sel enum (ADDR, BEGIN, MIDDLE, END), status code constants (1,2,3,4,4'hF) and FSM state enum.
REQ-033 One sub-module, mem_op_target: combinational req_sel/req_addr -> target address decode.
REQ-034 Storage inferred inside mem_op_ctrl as DEPTH x DATA_W register array; no simulation-only display tasks in RTL.

Verification (DATA_W=32, ADDR_W=3)
REQ-035 Reset, then READ sel=3 -> next cycle rsp_data=0, rsp_addr=7, rsp_last=1, status=2.
REQ-036 WRITE sel=2 data 32'hA5A5_0001, then READ sel=0 addr=4 next cycle -> rsp_data=32'hA5A5_0001, status=2.
REQ-037 FILL data 32'hDEAD_BEEF -> busy and req_ready=0 for 8 cycles, done with status=3; then DUMP -> 8 rsp_valid cycles addr 0..7 all 32'hDEAD_BEEF, rsp_last on addr 7, status=4.
REQ-038 req_valid with op=3 held during FILL -> ignored until IDLE, then accepted; no memory corruption.
REQ-039 req_op=6 -> done, status=4'hF, rsp_valid=0, subsequent DUMP unchanged.
REQ-040 rst pulsed at DUMP word 3 -> rsp_valid=0 immediately, no done, DUMP after release returns all zeros.
